ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of imem.
- Generates the PC and drives imem_pc/imem_rd_en, accounting for imem's one-cycle registered-address read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and misaligned-PC faults.

Parameters:
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- imem_rd_en  out  1  read request to imem, sampled by imem at posedge.
- imem_pc  out  XLEN  byte address to imem, always word aligned when imem_rd_en=1.
- imem_instr  in  XLEN  imem read data, valid in the cycle after the request edge.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  XLEN  new fetch address.
- out_valid  out  1  entry available to decode.
- out_ready  in  1  decode accepts.
- out_instr  out  XLEN  instruction.
- out_pc  out  XLEN  PC of out_instr.
- out_fault  out  1  entry is a misaligned-fetch fault (out_instr=0).

Behaviour:
- Reset (rst==0 at posedge):
  - pc_reg=RESET_PC, FIFO emptied, in-flight flag cleared, state=FETCH.
  - imem_rd_en=0, out_valid=0, out_instr=0, out_pc=0, out_fault=0.
  - Mid-operation reset drops any in-flight response; imem_instr is ignored in the following cycle.
- States:
  - FETCH: normal operation.
  - HALT: after a fault entry is enqueued; no requests issued.
  - HALT -> FETCH only on redirect_valid with an aligned PC.
- Credit: pop = out_valid & out_ready. Issue condition (combinational, FETCH only, no redirect this cycle): count + inflight - pop < BUF_DEPTH.
- Issue: imem_rd_en=1, imem_pc=pc_reg. At the edge: pc_reg += 4 (wraps modulo 2^XLEN), inflight=1, req_pc=pc_reg.
- Response: in the cycle with inflight=1, imem_instr is written to the FIFO tail with req_pc at the edge. inflight clears unless a new issue happens in the same cycle.
- Throughput: one instruction per cycle sustained when out_ready=1.
- Latency: issue edge E, data captured at E+1, out_valid in the cycle after E+1. Reset release to first out_valid = 2 cycles.
- FIFO:
  - Registered outputs; out_* show the head entry.
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot). Push never occurs while full because of the credit rule.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Redirect (highest priority):
  - At the edge: FIFO cleared, in-flight response marked discard, pc_reg=redirect_pc, state=FETCH.
  - No issue in the redirect cycle. Any pop in that cycle counts as flushed.
  - First request with imem_pc=redirect_pc is in the next cycle.
- Misaligned PC (pc_reg[1:0]!=0) in FETCH:
  - No imem request.
  - When FIFO space is available, push {instr=0, pc=pc_reg, fault=1} and go to HALT.
  - The fault entry drains normally.
- Redirect coinciding with response arrival: the response is discarded. Redirect coinciding with reset: reset wins.

Decomposition:
- riscv_pkg:
  - XLEN, RESET_PC, INSTR_BYTES=4.
  - fetch_entry_t struct {instr, pc, fault}.
  - fetch_state_e {FETCH, HALT}.
- Sub-module fetch_buf: synchronous FIFO of fetch_entry_t, BUF_DEPTH parameter, ports push/pop/flush/count/head. The top holds the PC, credit logic and FSM.

Test Plan:
- Reset then out_ready=1, imem preloaded with 0x00000013 at word i -> out_pc 0,4,8,... consecutive every cycle, first out_valid 2 cycles after rst=1.
- out_ready=0 for 5 cycles after 2 entries -> imem_rd_en low once count+inflight=2, out_pc=0 held, no lost/duplicated PC after release.
- redirect_valid with redirect_pc=0x40 while an entry is in flight -> flushed entries never emitted, next out_pc=0x40, then 0x44.
- redirect_pc=0x43 -> no imem_rd_en, one entry out_fault=1, out_pc=0x43, out_instr=0, then idle until redirect to 0x80 resumes.
- rst=0 asserted the cycle after an issue -> no entry from that read appears, fetch restarts at RESET_PC.
- Random out_ready over 200 cycles -> out_pc strictly sequential, out_instr equals model memory word pc>>2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;

  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
  localparam int              INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries; head is presented straight from storage.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so push is honoured even when full.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; head is masked to zero while empty, so stale words never reach decode.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC generation, credit-based imem requests, redirect flush and
// misaligned-PC fault handling in front of the fetch_buf output FIFO.
module ifetch_unit
  import riscv_pkg::fetch_entry_t, riscv_pkg::fetch_state_e, riscv_pkg::FETCH,
         riscv_pkg::HALT, riscv_pkg::INSTR_BYTES;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     committed;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            pop;
  logic            push;
  logic            issue;
  logic            resp_push;
  logic            fault_push;
  logic            credit_ok;
  logic            pc_aligned;

  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  // Slots already owed: buffered entries plus the outstanding read, less this cycle's pop.
  assign committed  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit_ok  = committed < (CW+1)'(BUF_DEPTH);
  assign pc_aligned = (pc_reg[1:0] == 2'b00);
  // A redirect in the response cycle drops the returning word.
  assign resp_push  = inflight && !redirect_valid;
  assign push       = resp_push || fault_push;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    issue      = 1'b0;
    fault_push = 1'b0;
    state_d    = state_q;
    if (redirect_valid) begin
      state_d = (redirect_pc[1:0] == 2'b00 || state_q == FETCH) ? FETCH : HALT;
    end else if (rst && state_q == FETCH && credit_ok) begin
      if (pc_aligned) begin
        issue = 1'b1;
      end else if (!inflight) begin
        fault_push = 1'b1;
        state_d    = HALT;
      end
    end
  end

  always_comb begin
    push_data = '{instr: imem_instr, pc: req_pc, fault: 1'b0};
    if (fault_push) push_data = '{instr: {XLEN{1'b0}}, pc: pc_reg, fault: 1'b1};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_reg   <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= issue;
      if (redirect_valid) begin
        pc_reg <= redirect_pc;
      end else if (issue) begin
        pc_reg <= pc_reg + XLEN'(INSTR_BYTES);
        req_pc <= pc_reg;
      end
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign imem_rd_en = issue;
  assign imem_pc    = pc_reg;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
  assign out_fault  = head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: registered imem model, scoreboard of
// expected {pc, instr, fault} entries, redirect vector table and corner sequences.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          n_out;
    logic        fault;
  } vec_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rd_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        hold_fault;

  ifetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[21:2], 12'h013};
  endfunction

  // imem: address registered at the request edge, data valid the following cycle.
  always @(posedge clk) begin
    if (imem_rd_en) imem_instr <= mem_word(imem_pc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] p;
      p = start + 32'(4 * k);
      exp_q.push_back('{pc: p, instr: mem_word(p), fault: 1'b0});
    end
  endtask

  task automatic wait_acc(input string name, input int n, input int budget);
    int start;
    int c;
    start = n_acc;
    c     = 0;
    while ((n_acc - start) < n && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    check(name, 32'((n_acc - start) >= n), 32'd1);
  endtask

  // Scoreboard: every accepted output outside reset/redirect cycles is compared.
  always @(negedge clk) begin
    if (rst && !redirect_valid) begin
      if (hold_prev) begin
        check("hold_pc", out_pc, hold_pc);
        check("hold_instr", out_instr, hold_instr);
        check("hold_fault", 32'(out_fault), 32'(hold_fault));
      end
      if (imem_rd_en) check("rd_align", 32'(imem_pc[1:0]), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          check("out_fault", 32'(out_fault), 32'(e.fault));
        end
        n_acc++;
      end
      hold_prev  = out_valid && !out_ready;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      hold_fault = out_fault;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   a;
    vecs[0] = '{32'h0000_0040, 4, 1'b0};
    vecs[1] = '{32'h0000_0043, 1, 1'b1};
    vecs[2] = '{32'h0000_0080, 4, 1'b0};
    vecs[3] = '{32'hFFFF_FFF8, 4, 1'b0};
    vecs[4] = '{32'h0000_0002, 1, 1'b1};
    vecs[5] = '{32'h0000_0100, 3, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);

    // Release: first request at RESET_PC, first out_valid two edges later
    expect_stream(RESET_PC, 64);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("first_req_en", 32'(imem_rd_en), 32'd1);
    check("first_req_pc", imem_pc, RESET_PC);
    check("lat_valid_c0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_c2", 32'(out_valid), 32'd1);

    // Sustained throughput
    @(posedge clk); #2;
    a = n_acc;
    repeat (8) begin @(posedge clk); #2; end
    check("throughput", 32'(n_acc - a), 32'd8);

    // Back-pressure: requests stop once buffer plus in-flight covers the depth
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      if (i >= 1) check("stall_no_req", 32'(imem_rd_en), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_acc("stall_resume", 6, 20);

    // Redirect table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      exp_q.delete();
      if (vecs[i].fault) exp_q.push_back('{pc: vecs[i].target, instr: 32'd0, fault: 1'b1});
      else expect_stream(vecs[i].target, 64);
      @(negedge clk);
      check("redir_no_req", 32'(imem_rd_en), 32'd0);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      if (!vecs[i].fault) begin
        check("redir_req_en", 32'(imem_rd_en), 32'd1);
        check("redir_req_pc", imem_pc, vecs[i].target);
      end else begin
        check("fault_no_req", 32'(imem_rd_en), 32'd0);
      end
      wait_acc("redir_outputs", vecs[i].n_out, 20);
      if (vecs[i].fault) begin
        repeat (4) begin
          @(negedge clk);
          check("halt_no_req", 32'(imem_rd_en), 32'd0);
          check("halt_idle", 32'(out_valid), 32'd0);
        end
      end
    end

    // Reset the cycle after an issue: that read never appears
    @(negedge clk);
    check("pre_rst_issue", 32'(imem_rd_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_rd_en", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    expect_stream(RESET_PC, 64);
    @(posedge clk); #1 rst = 1'b1;
    wait_acc("restart", 4, 20);

    // Random back-pressure
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    exp_q.delete();
    expect_stream(32'h0000_0200, 256);
    @(posedge clk); #1 redirect_valid = 1'b0;
    a = n_acc;
    repeat (200) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("random_progress", 32'((n_acc - a) > 20), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
